// File: rtl/instr_fetch_stage_if.sv
// Instruction memory req/ack bus between the fetch stage and imem.
// The fetch stage is the master; memory is the slave.
interface instr_fetch_stage_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: holds PC, fetches over req/ack, issues Instr downstream,
// computes PC+4 or PC+ImmOp, counts retired instructions.
module instr_fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  instr_fetch_stage_if.master      imem,
  input  logic                     stall,
  input  logic                     PCsrc,
  input  logic [INSTR_WIDTH-1:0]   ImmOp,
  output logic [INSTR_WIDTH-1:0]   Instr,
  output logic                     instr_valid,
  output logic [ADDR_WIDTH-1:0]    PC,
  output logic                     misalign_err,
  output logic [31:0]              retire_count
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   req;

  assign req = (state_q == FETCH) && en && !rst;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign target = PCsrc ? pc_q + ImmOp[ADDR_WIDTH-1:0]
                        : pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (req && imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          valid_d = 1'b0;
          // misaligned targets park the stage until reset
          if (target[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            cnt_d   = cnt_q + 32'd1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Instr        = instr_q;
  assign instr_valid  = valid_q;
  assign PC           = pc_q;
  assign misalign_err = err_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage with a
// transaction-level model of fetch/issue and random stimulus.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, en, stall, PCsrc;
  logic [31:0] ImmOp, Instr, PC, retire_count;
  logic        instr_valid, misalign_err;

  instr_fetch_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instr_fetch_stage #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .imem(bus.master),
    .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .Instr(Instr), .instr_valid(instr_valid), .PC(PC),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model: architectural PC, last instruction, retired count, error
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic fetch_one(input int waits, input logic [31:0] data);
    for (int w = 0; w < waits; w++) begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
      #1;
      chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("wait_addr", bus.imem_addr, m_pc);
      step();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      chk("wait_instr", Instr, m_instr);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    #1;
    chk("ack_req", {31'd0, bus.imem_req}, 32'd1);
    chk("ack_addr", bus.imem_addr, m_pc);
    step();
    bus.imem_ack = 1'b0;
    m_instr = data;
    chk("cap_instr", Instr, m_instr);
    chk("cap_valid", {31'd0, instr_valid}, 32'd1);
    chk("cap_pc", PC, m_pc);
  endtask

  task automatic issue_one(input int stalls, input logic src,
                           input logic [31:0] imm);
    logic [31:0] tgt;
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      PCsrc = 1'($urandom);
      ImmOp = $urandom;
      step();
      chk("stall_instr", Instr, m_instr);
      chk("stall_pc", PC, m_pc);
      chk("stall_cnt", retire_count, m_cnt);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    PCsrc = src;
    ImmOp = imm;
    step();
    PCsrc = 1'b0;
    ImmOp = $urandom;
    tgt = src ? m_pc + imm : m_pc + 32'd4;
    if (tgt % 4 != 0) begin
      m_err = 1'b1;
    end else begin
      m_pc  = tgt;
      m_cnt = m_cnt + 1;
    end
    chk("iss_pc", PC, m_pc);
    chk("iss_cnt", retire_count, m_cnt);
    chk("iss_err", {31'd0, misalign_err}, {31'd0, m_err});
    chk("iss_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic jump_to(input logic [31:0] dest);
    fetch_one(0, $urandom);
    issue_one(0, 1'b1, dest - m_pc);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    step();
    step();
    m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_cnt", retire_count, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
  endtask

  task automatic test_basic();
    fetch_one(0, 32'h00000013);
    issue_one(0, 1'b0, 32'h0);
    chk("basic_pc", PC, 32'h4);
    chk("basic_cnt", retire_count, 32'd1);
  endtask

  task automatic test_branch();
    jump_to(32'h10);
    fetch_one(0, $urandom);
    issue_one(0, 1'b1, 32'hFFFFFFF8);
    #1;
    chk("br_back_addr", bus.imem_addr, 32'h08);
    jump_to(32'h10);
    fetch_one(0, $urandom);
    issue_one(0, 1'b1, 32'h00000800);
    #1;
    chk("br_fwd_addr", bus.imem_addr, 32'h810);
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    fetch_one(0, $urandom);
    p0 = m_pc;
    issue_one(3, 1'b0, 32'h0);
    chk("stall_adv", PC, p0 + 32'd4);
  endtask

  task automatic test_wait_states();
    logic [31:0] keep;
    en = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = $urandom;
    #1;
    chk("noen_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("noen_ack_ign", {31'd0, instr_valid}, 32'd0);
    bus.imem_ack = 1'b0;
    en = 1'b1;
    fetch_one(3, $urandom);
    keep = m_instr;
    stall = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = ~keep;
    step();
    bus.imem_ack = 1'b0;
    chk("spur_instr", Instr, keep);
    chk("spur_valid", {31'd0, instr_valid}, 32'd1);
    issue_one(0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      fetch_one(int'($urandom_range(0, 3)), $urandom);
      issue_one(int'($urandom_range(0, 2)), 1'($urandom),
                $urandom & 32'hFFFF_FFFC);
    end
  endtask

  task automatic test_wrap_midreset();
    jump_to(32'hFFFFFFFC);
    fetch_one(0, $urandom);
    issue_one(0, 1'b0, 32'h0);
    chk("wrap_pc", PC, 32'h0);
    fetch_one(0, $urandom);
    issue_one(0, 1'b0, 32'h0);
    bus.imem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBADC0DE0;
    step();
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
    chk("mr_instr", Instr, 32'h0);
    chk("mr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_pc", PC, 32'h0);
    chk("mr_cnt", retire_count, 32'h0);
    fetch_one(1, 32'h00100093);
    issue_one(0, 1'b0, 32'h0);
  endtask

  task automatic test_misalign();
    logic [31:0] c0;
    jump_to(32'h20);
    fetch_one(0, $urandom);
    c0 = m_cnt;
    issue_one(0, 1'b1, 32'h2);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_pc", PC, 32'h20);
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack = 1'b1;
      #1;
      chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
      step();
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_cnt", retire_count, c0);
    end
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("clr_err", {31'd0, misalign_err}, 32'd0);
    chk("clr_pc", PC, 32'h0);
    #1;
    chk("clr_req", {31'd0, bus.imem_req}, 32'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_wait_states();
    test_random();
    test_wrap_midreset();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
